uart_rx: RTL and testbench

Serial receive front end for the tst_6502 system. It sits directly downstream of the board-level RX pin and upstream of the CPU-side ACIA register interface. Each 8N1 frame is oversampled 16× from the system clock, and a small FIFO buffers the received bytes until the 6502 reads them. Framing errors and overruns are reported through sticky flags.

---
 rtl/uart_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling, sticky error flags and a receive buffer.
// Define RX_FIFO_EN for a 2^FIFO_AW-deep FIFO; otherwise a single holding register is used.
module uart_rx #(
    parameter int OVS_DIV = 26,
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       fifo_full,
    output logic       overrun,
    output logic       framing_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    localparam int PW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(OVS_DIV - 1);

    logic          sync1_r, sync2_r, rx_s;
    logic [PW-1:0] presc_r;
    logic          tick_s, presc_clr_s;
    state_t        state_r, state_nx_s;
    logic [3:0]    tick_cnt_r, tick_cnt_nx_s;
    logic [2:0]    bit_cnt_r, bit_cnt_nx_s;
    logic [7:0]    shift_r, shift_nx_s;
    logic          push_s, ferr_set_s, busy_r;
    logic          pop_s, push_ok_s, ovr_set_s;
    logic          overrun_r, framing_err_r;

    assign rx_s   = sync2_r;
    assign tick_s = (presc_r == PRESC_MAX);

    // Two-flop synchronizer for the asynchronous rx pin (idles high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Oversample prescaler, realigned to each detected start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
        end else if (presc_clr_s || tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Receiver next-state and datapath decode
    always_comb begin
        state_nx_s    = state_r;
        tick_cnt_nx_s = tick_cnt_r;
        bit_cnt_nx_s  = bit_cnt_r;
        shift_nx_s    = shift_r;
        push_s        = 1'b0;
        ferr_set_s    = 1'b0;
        presc_clr_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!rx_s) begin
                    presc_clr_s   = 1'b1;
                    tick_cnt_nx_s = 4'd0;
                    state_nx_s    = S_START;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_START: begin
                // Mid-bit check of the start bit rejects glitches
                if (tick_s && (tick_cnt_r == 4'd7)) begin
                    tick_cnt_nx_s = 4'd0;
                    bit_cnt_nx_s  = 3'd0;
                    state_nx_s    = rx_s ? S_IDLE : S_DATA;
                end else if (tick_s) begin
                    tick_cnt_nx_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nx_s = tick_cnt_r;
                end
            end
            S_DATA: begin
                if (tick_s && (tick_cnt_r == 4'd15)) begin
                    tick_cnt_nx_s = 4'd0;
                    shift_nx_s    = {rx_s, shift_r[7:1]};
                    bit_cnt_nx_s  = bit_cnt_r + 3'd1;
                    state_nx_s    = (bit_cnt_r == 3'd7) ? S_STOP : S_DATA;
                end else if (tick_s) begin
                    tick_cnt_nx_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nx_s = tick_cnt_r;
                end
            end
            S_STOP: begin
                if (tick_s && (tick_cnt_r == 4'd15)) begin
                    tick_cnt_nx_s = 4'd0;
                    push_s        = rx_s;
                    ferr_set_s    = !rx_s;
                    state_nx_s    = rx_s ? S_IDLE : S_WAIT_HI;
                end else if (tick_s) begin
                    tick_cnt_nx_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nx_s = tick_cnt_r;
                end
            end
            S_WAIT_HI: begin
                if (rx_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_WAIT_HI;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Receiver state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            tick_cnt_r <= tick_cnt_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            shift_r    <= shift_nx_s;
            busy_r     <= (state_nx_s != S_IDLE);
        end
    end

`ifdef RX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]     mem_r [DEPTH];
    logic [FIFO_AW:0] wr_ptr_r, rd_ptr_r;
    logic           empty_s, full_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                       (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    assign pop_s     = rd && !empty_s;
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign ovr_set_s = push_s && full_s && !pop_s;

    // Circular buffer storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[FIFO_AW-1:0]] <= shift_r;
                wr_ptr_r <= wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    assign rdata     = mem_r[rd_ptr_r[FIFO_AW-1:0]];
    assign rvalid    = !empty_s;
    assign fifo_full = full_s;
`else
    logic [7:0] hold_r;
    logic       valid_r;
    logic       unused_cfg_s;

    assign unused_cfg_s = (FIFO_AW > 0);
    assign pop_s        = rd && valid_r;
    assign push_ok_s    = push_s && (!valid_r || pop_s);
    assign ovr_set_s    = push_s && valid_r && !pop_s;

    // Single-entry holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_r  <= 8'h00;
            valid_r <= 1'b0;
        end else if (push_ok_s) begin
            hold_r  <= shift_r;
            valid_r <= 1'b1;
        end else if (pop_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign rdata     = hold_r;
    assign rvalid    = valid_r;
    assign fifo_full = valid_r;
`endif

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r     <= 1'b0;
            framing_err_r <= 1'b0;
        end else begin
            overrun_r     <= ovr_set_s  || (overrun_r && !clr_err);
            framing_err_r <= ferr_set_s || (framing_err_r && !clr_err);
        end
    end

    assign overrun     = overrun_r;
    assign framing_err = framing_err_r;
    assign rx_busy     = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at OVS_DIV=1 (16 clocks per bit); honours RX_FIFO_EN.
module tb_uart_rx;

`ifdef RX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset, rx, rd, clr_err;
    logic [7:0] rdata;
    logic       rvalid, fifo_full, overrun, framing_err, rx_busy;

    uart_rx #(.OVS_DIV(1), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd(rd), .clr_err(clr_err),
        .rdata(rdata), .rvalid(rvalid), .fifo_full(fifo_full),
        .overrun(overrun), .framing_err(framing_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_cyc = 0;
    logic       rv_d = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_rvalid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle at which rvalid rises, for the latency check
    always @(negedge clk) begin
        if (rvalid && !rv_d) rise_cyc = cyc;
        rv_d = rvalid;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] dat(input int i);
        if (DEPTH == 1) return 8'(8'h11 * (i + 1));
        else return 8'(i);
    endfunction

    // One 8N1 frame, 160 clocks; rd is high at the posedge with index rd_at
    task automatic send_byte(input logic [7:0] d, input logic stop, input int rd_at);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        start_cyc = cyc;
        for (int k = 0; k < 160; k++) begin
            rx = fr[k/16];
            rd = (k == rd_at);
            @(negedge clk);
        end
        rd = 1'b0;
    endtask

    task automatic pop_check(input string nm);
        logic [7:0] e;
        e = exp_q.pop_front();
        check({nm, "_rvalid"}, 32'(rvalid), 32'd1);
        check({nm, "_rdata"}, 32'(rdata), 32'(e));
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0};

        reset = 1'b0; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
        tick(4);
        check("reset_outputs", 32'({rdata, rvalid, fifo_full, overrun, framing_err, rx_busy}), 32'd0);
        reset = 1'b1;
        tick(5);
        check("idle_outputs", 32'({rdata, rvalid, fifo_full, overrun, framing_err, rx_busy}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].data, vecs[i].stop, -1);
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            check("vec_rvalid", 32'(rvalid), 32'(vecs[i].exp_rvalid));
            check("vec_ferr", 32'(framing_err), 32'(vecs[i].exp_ferr));
            if (vecs[i].stop) begin
                check("vec_latency_ok", 32'((rise_cyc - start_cyc >= 150) && (rise_cyc - start_cyc <= 156)), 32'd1);
                check("vec_busy_after", 32'(rx_busy), 32'd0);
                pop_check("vec_pop");
                check("vec_empty_after_rd", 32'(rvalid), 32'd0);
            end else begin
                tick(20);
                check("wait_hi_busy", 32'(rx_busy), 32'd1);
                check("wait_hi_rvalid", 32'(rvalid), 32'd0);
                rx = 1'b1;
                tick(4);
                check("wait_hi_exit", 32'(rx_busy), 32'd0);
                pulse_clr();
                check("ferr_cleared", 32'(framing_err), 32'd0);
            end
        end

        // False start: short low pulse must not start a frame
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(12);
        check("false_start_busy", 32'(rx_busy), 32'd0);
        check("false_start_out", 32'({rvalid, overrun, framing_err}), 32'd0);

        // Overrun: one more byte than the buffer holds, no reads
        for (int i = 0; i <= DEPTH; i++) begin
            send_byte(dat(i), 1'b1, -1);
            if (i < DEPTH) exp_q.push_back(dat(i));
        end
        check("ovr_full", 32'(fifo_full), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovr_drain");
        check("ovr_empty", 32'(rvalid), 32'd0);
        check("ovr_not_full", 32'(fifo_full), 32'd0);
        pulse_clr();
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(dat(i), 1'b1, -1);
            exp_q.push_back(dat(i));
        end
        check("sim_full_before", 32'(fifo_full), 32'd1);
        void'(exp_q.pop_front());
        exp_q.push_back(dat(DEPTH));
        send_byte(dat(DEPTH), 1'b1, 154);
        check("sim_no_overrun", 32'(overrun), 32'd0);
        check("sim_full_after", 32'(fifo_full), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check("sim_drain");
        check("sim_empty", 32'(rvalid), 32'd0);

        // Reset in the middle of a frame with data buffered
        send_byte(8'h77, 1'b1, -1);
        check("mid_rst_pre_valid", 32'(rvalid), 32'd1);
        rx = 1'b0;
        tick(50);
        reset = 1'b0;
        rx = 1'b1;
        tick(3);
        check("mid_rst_out", 32'({rdata, rvalid, fifo_full, rx_busy}), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        tick(3);
        send_byte(8'h3C, 1'b1, -1);
        exp_q.push_back(8'h3C);
        pop_check("post_rst");
        check("post_rst_empty", 32'(rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
